// File: rtl/mode4_exp_accum_pkg.sv
// Shared fp16 constants and helpers for the mode-4 exp accumulator.
// Also provides the `DATAWIDTH/`MANTISSA/`EXPONENT/`IEEE_COMPLIANCE/`FP16_* macros.
`ifndef MODE4_EXP_ACCUM_DEFINES
`define MODE4_EXP_ACCUM_DEFINES
`define DATAWIDTH 16
`define MANTISSA 10
`define EXPONENT 5
`define IEEE_COMPLIANCE 1
`define FP16_ZERO 16'h0000
`define FP16_MAX_FINITE 16'h7BFF
`define FP16_POS_INF 16'h7C00
`endif

package mode4_exp_accum_pkg;

   localparam int unsigned DataWidth = `DATAWIDTH;
   localparam int unsigned MantWidth = `MANTISSA;
   localparam int unsigned ExpWidth  = `EXPONENT;

   localparam logic [DataWidth-1:0] FP16Zero      = `FP16_ZERO;
   localparam logic [DataWidth-1:0] FP16MaxFinite = `FP16_MAX_FINITE;
   localparam logic [DataWidth-1:0] FP16PosInf    = `FP16_POS_INF;

   // All-ones exponent field: the operand is an infinity or a NaN.
   function automatic logic is_inf_nan(input logic [DataWidth-1:0] x);
      return &x[MantWidth +: ExpWidth];
   endfunction

endpackage

// File: rtl/mode4_fp_add.sv
// Combinational fp16 adder, round-to-nearest-even, with guard/round/sticky alignment.
// IeeeCompliance=0 flushes denormal operands and results to signed zero.
module mode4_fp_add
   import mode4_exp_accum_pkg::*;
#(
   parameter int unsigned IeeeCompliance = `IEEE_COMPLIANCE
) (
   input  logic [DataWidth-1:0] a,
   input  logic [DataWidth-1:0] b,
   output logic [DataWidth-1:0] z
);

   logic        a_nan, b_nan, a_inf, b_inf, a_big, eff_sub;
   logic [4:0]  a_e, b_e, big_e, sml_e, d;
   logic [10:0] a_m, b_m, big_m, sml_m;
   logic        big_s;
   logic [45:0] sml_wide;
   logic [13:0] big_x, sml_x, mant;
   logic [14:0] s;
   logic [5:0]  e;
   logic [3:0]  lz;
   logic        rup;
   logic [15:0] val;

   always_comb begin
      a_nan = (&a[14:10]) & (|a[9:0]);
      b_nan = (&b[14:10]) & (|b[9:0]);
      a_inf = (&a[14:10]) & ~(|a[9:0]);
      b_inf = (&b[14:10]) & ~(|b[9:0]);

      // Denormals use exponent 1 with no hidden bit.
      a_e = (a[14:10] == 5'd0) ? 5'd1 : a[14:10];
      b_e = (b[14:10] == 5'd0) ? 5'd1 : b[14:10];
      a_m = {a[14:10] != 5'd0, a[9:0]};
      b_m = {b[14:10] != 5'd0, b[9:0]};
      if (IeeeCompliance == 0) begin
         if (a[14:10] == 5'd0) a_m = '0;
         if (b[14:10] == 5'd0) b_m = '0;
      end

      a_big   = a[14:0] >= b[14:0];
      big_s   = a_big ? a[15] : b[15];
      big_e   = a_big ? a_e : b_e;
      sml_e   = a_big ? b_e : a_e;
      big_m   = a_big ? a_m : b_m;
      sml_m   = a_big ? b_m : a_m;
      eff_sub = a[15] ^ b[15];

      d        = big_e - sml_e;
      sml_wide = {sml_m, 3'b000, 32'd0} >> d;
      sml_x    = {sml_wide[45:33], |sml_wide[32:0]};
      big_x    = {big_m, 3'b000};
      s        = eff_sub ? ({1'b0, big_x} - {1'b0, sml_x}) : ({1'b0, big_x} + {1'b0, sml_x});

      lz = 4'd14;
      for (int i = 0; i < 14; i++) begin
         if (s[i]) lz = 4'(13 - i);
      end

      e = {1'b0, big_e};
      if (s[14]) begin
         mant = {s[14:2], s[1] | s[0]};
         e    = e + 6'd1;
      end else if ({2'b00, lz} < e) begin
         mant = s[13:0] << lz;
         e    = e - {2'b00, lz};
      end else begin
         // Normalisation stops at the minimum exponent: the result is denormal.
         mant = s[13:0] << (e - 6'd1);
         e    = 6'd1;
      end

      rup = mant[2] & (mant[1] | mant[0] | mant[3]);
      // Rounding carries ripple naturally into the exponent field.
      val = {(mant[13] ? e : 6'd0), mant[12:3]} + 16'(rup);

      if (val[15:10] >= 6'd31) begin
         z = {big_s, 5'h1F, 10'd0};
      end else if ((IeeeCompliance == 0) && (val[14:10] == 5'd0)) begin
         z = {big_s, 15'd0};
      end else begin
         z = {big_s, val[14:0]};
      end

      if (s == 15'd0) z = {big_s & ~eff_sub, 15'd0};

      if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
         z = 16'h7E00;
      end else if (a_inf) begin
         z = a;
      end else if (b_inf) begin
         z = b;
      end
   end

endmodule

// File: rtl/mode4_exp_accum.sv
// Accumulates NUM_ELEMS fp16 exp values in arrival order and hands the sum to the ln stage.
// Optional MODE4_SAT_EN clamps adder overflow from finite operands to the largest finite value.
module mode4_exp_accum
   import mode4_exp_accum_pkg::*;
#(
   parameter int unsigned NUM_ELEMS = 64,
   parameter int unsigned CNT_W     = $clog2(NUM_ELEMS + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DataWidth-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DataWidth-1:0] out_data
);

   typedef enum logic {StAccum = 1'b0, StDone = 1'b1} state_e;

   state_e               state_q, state_d;
   logic [DataWidth-1:0] acc_q, acc_d, sum, sum_sel;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   mode4_fp_add #(
      .IeeeCompliance(`IEEE_COMPLIANCE)
   ) u_fp_add (
      .a(acc_q),
      .b(in_data),
      .z(sum)
   );

`ifdef MODE4_SAT_EN
   assign sum_sel = ((sum == FP16PosInf) && !is_inf_nan(acc_q) && !is_inf_nan(in_data)) ?
                    FP16MaxFinite : sum;
`else
   assign sum_sel = sum;
`endif

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         StAccum: begin
            in_ready = 1'b1;
            if (in_valid) begin
               acc_d = sum_sel;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(NUM_ELEMS - 1)) state_d = StDone;
            end
         end
         StDone: begin
            out_valid = 1'b1;
            if (out_ready) begin
               acc_d   = FP16Zero;
               cnt_d   = '0;
               state_d = StAccum;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StAccum;
         acc_q   <= FP16Zero;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_data = acc_q;

endmodule
